stepper_pulse_generator: RTL
============================

# stepper_pulse_generator

Dual-axis step/direction pulse generator sitting downstream of the SCARA controller: it accepts a relative move command (8-bit step counts plus direction per joint) on a rising-edge `dataReady` strobe and emits the matching step pulse trains on the motor driver pins. It holds `stepperReady` low for the whole move and raises it again when the last pulse period has elapsed; the controller's ready latch is set from that signal. Both axes step at the same fixed rate, starting together; the shorter axis simply stops early.

## Interface
- `CLK_DIV`, default 50000: clock cycles per step period; must be ≥ 2.
- `PULSE_WIDTH`, default 100: step pulse high time in cycles; must satisfy 1 ≤ PULSE_WIDTH < CLK_DIV.
- `DIR_SETUP`, default 50: cycles between the direction pins updating and the first step edge; must be ≥ 1.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `dataReady`  in  1  command strobe; a command is taken on its rising edge
- `steps1`  in  8  joint-1 step count, unsigned
- `steps2`  in  8  joint-2 step count, unsigned
- `dir1`  in  1  joint-1 direction
- `dir2`  in  1  joint-2 direction
- `step1Out`  out  1  joint-1 step pin
- `step2Out`  out  1  joint-2 step pin
- `dir1Out`  out  1  joint-1 direction pin, registered
- `dir2Out`  out  1  joint-2 direction pin, registered
- `stepperReady`  out  1  high = idle, can take a command
- `cmdDropped`  out  1  one-cycle pulse when a command edge arrives while busy

## Operation
- Reset values:
  - `step1Out`, `step2Out`, `dir1Out`, `dir2Out`, `cmdDropped` = 0.
  - `stepperReady` = 1.
  - State = IDLE; remaining counts, period counter and edge-detect register all cleared. The edge-detect register clears to 0, so `dataReady` held high through reset counts as an edge on the first cycle after reset.
- Edge detect: `dReg` <= `dataReady` every cycle; `edge` = `dataReady & ~dReg`.
- IDLE:
  - On `edge`, latch `steps1`/`steps2` into `rem1`/`rem2` and `dir1`/`dir2` into `dir1Out`/`dir2Out`.
  - Clear `stepperReady` and go to SETUP.
- SETUP:
  - Count DIR_SETUP cycles.
  - At the end: if `rem1` = `rem2` = 0, go to DONE; otherwise go to RUN with period counter = 0.
- RUN:
  - The period counter runs 0..CLK_DIV-1 and wraps.
  - At count 0, each axis with `remN` > 0 raises `stepNOut` and decrements `remN`. `stepNOut` is high while count < PULSE_WIDTH.
  - At count CLK_DIV-1 with `rem1` = `rem2` = 0, go to DONE.
- DONE: one cycle, then IDLE with `stepperReady` = 1.
- `edge` in any state other than IDLE: the command is ignored, `cmdDropped` pulses for 1 cycle, and the latched move is unaffected.
- A level-high `dataReady` lasting past the end of the move does not retrigger; a new low→high transition is required.
- Reset mid-move: every output and the state return to their reset values at that edge. Pulses are truncated and the remaining steps are discarded.

## Timing
- Edge sampled at clock edge k:
  - `dir1Out`, `dir2Out` valid and `stepperReady` = 0 after edge k.
  - The first step rise follows DIR_SETUP cycles later (after edge k+DIR_SETUP).
- Each pulse is exactly PULSE_WIDTH cycles high; the rise-to-rise spacing is exactly CLK_DIV cycles.
- Busy time with N = max(`steps1`, `steps2`): `stepperReady` is low for DIR_SETUP + N·CLK_DIV + 1 cycles. For N = 0 this is DIR_SETUP + 1.
- An edge sampled on the first IDLE cycle after DONE is accepted; there are no dead cycles.
- Axis 1 and axis 2 rise on the same cycle while both still have steps remaining.

## Test plan
Params for all scenarios: CLK_DIV=10, PULSE_WIDTH=3, DIR_SETUP=4.
- **Reset defaults.** Reset 2 cycles → all outputs 0 except `stepperReady` = 1; no pulses with `dataReady` = 0 for 100 cycles.
- **Unequal move.** `steps1`=3, `steps2`=1, `dir1`=1, `dir2`=0, 1-cycle strobe at edge k →
  - `dir1Out`=1 after edge k; `stepperReady` low for 4+30+1 = 35 cycles.
  - `step1Out` rises at k+4, k+14, k+24, each 3 cycles high.
  - `step2Out` rises only at k+4.
- **Zero move.** `steps1`=`steps2`=0 → no step pulses; `stepperReady` low for exactly 5 cycles.
- **Busy collision.** Strobe a 2-step move, then a second rising edge 8 cycles later → `cmdDropped` pulses once; exactly 2 pulses per axis total; `stepperReady` low for 25 cycles.
- **Held level and boundary count.** `dataReady` held high for 200 cycles with `steps1`=255 → exactly one move accepted; 255 pulses on `step1Out`; no retrigger after DONE.
- **Reset mid-move.** Reset asserted at the 2nd pulse of a 5-step move → outputs go to reset values at the next edge; `stepperReady` = 1; no further pulses.

Source files
------------

// File: rtl/stepper_pulse_generator.sv
// Dual-axis step/direction pulse generator: latches a relative move on a dataReady rising edge
// and emits CLK_DIV-spaced, PULSE_WIDTH-wide step pulses on both axes, starting together.
module stepper_pulse_generator #(
  parameter int CLK_DIV     = 50000,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dataReady,
  input  logic [7:0] steps1,
  input  logic [7:0] steps2,
  input  logic       dir1,
  input  logic       dir2,
  output logic       step1Out,
  output logic       step2Out,
  output logic       dir1Out,
  output logic       dir2Out,
  output logic       stepperReady,
  output logic       cmdDropped
);

  // One counter serves both the direction-setup wait and the step period.
  localparam int CNT_MAX = (CLK_DIV > DIR_SETUP) ? CLK_DIV : DIR_SETUP;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] PW_LAST    = CW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    rem1, rem1_nxt, rem2, rem2_nxt;
  logic          step1_nxt, step2_nxt, dir1_nxt, dir2_nxt, ready_nxt, dropped_nxt;
  logic          dready_prev;
  logic          edge_det;

  assign edge_det = dataReady & ~dready_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rem1         <= '0;
      rem2         <= '0;
      dready_prev  <= 1'b0;
      step1Out     <= 1'b0;
      step2Out     <= 1'b0;
      dir1Out      <= 1'b0;
      dir2Out      <= 1'b0;
      stepperReady <= 1'b1;
      cmdDropped   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rem1         <= rem1_nxt;
      rem2         <= rem2_nxt;
      dready_prev  <= dataReady;
      step1Out     <= step1_nxt;
      step2Out     <= step2_nxt;
      dir1Out      <= dir1_nxt;
      dir2Out      <= dir2_nxt;
      stepperReady <= ready_nxt;
      cmdDropped   <= dropped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem1_nxt    = rem1;
    rem2_nxt    = rem2;
    step1_nxt   = step1Out;
    step2_nxt   = step2Out;
    dir1_nxt    = dir1Out;
    dir2_nxt    = dir2Out;
    ready_nxt   = stepperReady;
    dropped_nxt = edge_det && (state != IDLE);

    case (state)
      IDLE: begin
        if (edge_det) begin
          rem1_nxt  = steps1;
          rem2_nxt  = steps2;
          dir1_nxt  = dir1;
          dir2_nxt  = dir2;
          ready_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nxt = '0;
          if (rem1 == 8'd0 && rem2 == 8'd0) begin
            state_nxt = DONE;
          end else begin
            // Entering RUN at count 0 fires the first pulse on this same edge.
            state_nxt = RUN;
            if (rem1 != 8'd0) begin
              step1_nxt = 1'b1;
              rem1_nxt  = rem1 - 8'd1;
            end
            if (rem2 != 8'd0) begin
              step2_nxt = 1'b1;
              rem2_nxt  = rem2 - 8'd1;
            end
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt = '0;
          if (rem1 == 8'd0 && rem2 == 8'd0) begin
            state_nxt = DONE;
          end else begin
            if (rem1 != 8'd0) begin
              step1_nxt = 1'b1;
              rem1_nxt  = rem1 - 8'd1;
            end
            if (rem2 != 8'd0) begin
              step2_nxt = 1'b1;
              rem2_nxt  = rem2 - 8'd1;
            end
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == PW_LAST) begin
            step1_nxt = 1'b0;
            step2_nxt = 1'b0;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
